// File: rtl/unified_mem_arbiter_if.sv
// Unified memory port bus shared by the fetch and memory stages.
// The arbiter drives the request side; the memory drives ready and read data.
interface unified_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W/8-1:0]   mem_be;
   logic                  mem_ready;
   logic [DATA_W-1:0]     mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates fetch and data accesses onto one memory port, one transaction at a time,
// with data priority, fetch squash on redirect and a wait-cycle timeout abort.
//   state  | meaning
//   IDLE   | no transaction; arbitrate requests
//   BUSY_I | fetch on the bus, waiting for mem_ready or timeout
//   BUSY_D | data access on the bus, waiting for mem_ready or timeout
module unified_mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_if_req,
   input  logic [ADDR_W-1:0]     i_if_addr,
   input  logic                  i_flush,
   output logic                  o_if_valid,
   output logic [DATA_W-1:0]     o_if_rdata,
   output logic                  o_if_err,
   output logic                  o_stall_if,
   input  logic                  i_dm_req,
   input  logic                  i_dm_we,
   input  logic [ADDR_W-1:0]     i_dm_addr,
   input  logic [DATA_W-1:0]     i_dm_wdata,
   input  logic [DATA_W/8-1:0]   i_dm_be,
   output logic                  o_dm_valid,
   output logic [DATA_W-1:0]     o_dm_rdata,
   output logic                  o_dm_err,
   output logic                  o_stall_mem,
   unified_mem_arbiter_if.master mem
);
   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                squash_q, squash_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [BE_W-1:0]     be_q, be_d;
   logic                if_valid_q, if_valid_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic                if_err_q, if_err_d;
   logic                dm_valid_q, dm_valid_d;
   logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
   logic                dm_err_q, dm_err_d;

   logic                timeout_hit;
   logic                done;
   logic                squash_now;
   logic [DATA_W-1:0]   resp;

   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
   assign done        = mem.mem_ready || timeout_hit;
   assign squash_now  = squash_q || i_flush;
   // Aborts and stores both return zero data.
   assign resp        = (mem.mem_ready && !we_q) ? mem.mem_rdata : '0;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      squash_d   = squash_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      if_valid_d = 1'b0;
      if_rdata_d = if_rdata_q;
      if_err_d   = if_err_q;
      dm_valid_d = 1'b0;
      dm_rdata_d = dm_rdata_q;
      dm_err_d   = dm_err_q;

      case (state_q)
         IDLE: begin
            if (i_dm_req && !dm_valid_q) begin
               state_d = BUSY_D;
               cnt_d   = '0;
               addr_d  = i_dm_addr;
               we_d    = i_dm_we;
               wdata_d = i_dm_wdata;
               be_d    = i_dm_we ? i_dm_be : '1;
            end else if (i_if_req && !if_valid_q && !i_flush) begin
               state_d  = BUSY_I;
               cnt_d    = '0;
               squash_d = 1'b0;
               addr_d   = i_if_addr;
               we_d     = 1'b0;
               wdata_d  = '0;
               be_d     = '1;
            end
         end
         BUSY_I: begin
            if (done) begin
               state_d  = IDLE;
               squash_d = 1'b0;
               // A redirected fetch completes silently; the stage re-requests.
               if (!squash_now) begin
                  if_valid_d = 1'b1;
                  if_rdata_d = resp;
                  if_err_d   = !mem.mem_ready;
               end
            end else begin
               cnt_d    = cnt_q + CNT_W'(1);
               squash_d = squash_now;
            end
         end
         BUSY_D: begin
            if (done) begin
               state_d    = IDLE;
               dm_valid_d = 1'b1;
               dm_rdata_d = resp;
               dm_err_d   = !mem.mem_ready;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         squash_q   <= 1'b0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         be_q       <= '0;
         if_valid_q <= 1'b0;
         if_rdata_q <= '0;
         if_err_q   <= 1'b0;
         dm_valid_q <= 1'b0;
         dm_rdata_q <= '0;
         dm_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         squash_q   <= squash_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         if_valid_q <= if_valid_d;
         if_rdata_q <= if_rdata_d;
         if_err_q   <= if_err_d;
         dm_valid_q <= dm_valid_d;
         dm_rdata_q <= dm_rdata_d;
         dm_err_q   <= dm_err_d;
      end
   end

   assign mem.mem_req   = (state_q != IDLE);
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;
   assign mem.mem_be    = be_q;

   assign o_if_valid  = if_valid_q;
   assign o_if_rdata  = if_rdata_q;
   assign o_if_err    = if_err_q;
   assign o_dm_valid  = dm_valid_q;
   assign o_dm_rdata  = dm_rdata_q;
   assign o_dm_err    = dm_err_q;
   assign o_stall_if  = i_if_req && !if_valid_q;
   assign o_stall_mem = i_dm_req && !dm_valid_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model with a randomly stalling memory responder.
module tb_unified_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = 4;
   localparam int TO = 16;

   logic           clk = 1'b0;
   logic           reset;
   logic           i_if_req, i_flush, i_dm_req, i_dm_we;
   logic [AW-1:0]  i_if_addr, i_dm_addr;
   logic [DW-1:0]  i_dm_wdata;
   logic [BW-1:0]  i_dm_be;
   logic           o_if_valid, o_if_err, o_stall_if;
   logic           o_dm_valid, o_dm_err, o_stall_mem;
   logic [DW-1:0]  o_if_rdata, o_dm_rdata;

   unified_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .reset       (reset),
      .i_if_req    (i_if_req),
      .i_if_addr   (i_if_addr),
      .i_flush     (i_flush),
      .o_if_valid  (o_if_valid),
      .o_if_rdata  (o_if_rdata),
      .o_if_err    (o_if_err),
      .o_stall_if  (o_stall_if),
      .i_dm_req    (i_dm_req),
      .i_dm_we     (i_dm_we),
      .i_dm_addr   (i_dm_addr),
      .i_dm_wdata  (i_dm_wdata),
      .i_dm_be     (i_dm_be),
      .o_dm_valid  (o_dm_valid),
      .o_dm_rdata  (o_dm_rdata),
      .o_dm_err    (o_dm_err),
      .o_stall_mem (o_stall_mem),
      .mem         (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: one outstanding bus transaction, described by its owner,
   // latched request and how many bus cycles it has been running.
   bit          m_busy, m_is_data, m_squash, m_we;
   int          m_elapsed;
   logic [31:0] m_addr, m_wdata;
   logic [3:0]  m_be;
   bit          e_if_valid, e_dm_valid, e_if_err, e_dm_err;
   logic [31:0] e_if_rdata, e_dm_rdata;

   // Memory responder state
   bit          rnd_mode = 1'b0;
   int          next_wait = 0;
   int          wl = 0;
   logic        r_prev_req = 1'b0;
   logic [31:0] rd_val = '0;

   task automatic step();
      bit          el_dm, el_if, ok, sq;
      logic [31:0] res;
      @(negedge clk);
      if (reset) begin
         m_busy = 0; m_squash = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_be = '0;
         e_if_valid = 0; e_dm_valid = 0; e_if_err = 0; e_dm_err = 0;
         e_if_rdata = '0; e_dm_rdata = '0;
      end else begin
         el_dm = i_dm_req && !e_dm_valid;
         el_if = i_if_req && !e_if_valid && !i_flush;
         e_if_valid = 0;
         e_dm_valid = 0;
         if (m_busy) begin
            ok = bus.mem_ready;
            sq = m_squash || (i_flush && !m_is_data);
            if (ok || m_elapsed == TO) begin
               m_busy = 0;
               res = (ok && !m_we) ? bus.mem_rdata : 32'h0;
               if (m_is_data) begin
                  e_dm_valid = 1; e_dm_rdata = res; e_dm_err = !ok;
               end else if (!sq) begin
                  e_if_valid = 1; e_if_rdata = res; e_if_err = !ok;
               end
               m_squash = 0;
            end else begin
               m_elapsed++;
               m_squash = sq;
            end
         end else if (el_dm || el_if) begin
            m_busy = 1; m_elapsed = 1; m_squash = 0; m_is_data = el_dm;
            m_addr  = el_dm ? i_dm_addr : i_if_addr;
            m_we    = el_dm && i_dm_we;
            m_wdata = i_dm_wdata;
            m_be    = m_we ? i_dm_be : 4'hF;
         end
      end

      check("mem_req", bus.mem_req, m_busy);
      if (m_busy || reset) begin
         check("mem_addr", bus.mem_addr, m_addr);
         check("mem_we", bus.mem_we, m_we);
         check("mem_be", bus.mem_be, m_be);
         if (m_we || reset) check("mem_wdata", bus.mem_wdata, m_wdata);
      end
      check("if_valid", o_if_valid, e_if_valid);
      check("dm_valid", o_dm_valid, e_dm_valid);
      check("if_rdata", o_if_rdata, e_if_rdata);
      check("dm_rdata", o_dm_rdata, e_dm_rdata);
      if (e_if_valid) check("if_err", o_if_err, e_if_err);
      if (e_dm_valid) check("dm_err", o_dm_err, e_dm_err);
      check("stall_if", o_stall_if, i_if_req && !e_if_valid);
      check("stall_mem", o_stall_mem, i_dm_req && !e_dm_valid);

      if (bus.mem_req && !r_prev_req)
         wl = (next_wait >= 0) ? next_wait
            : (($urandom_range(0, 9) == 0) ? 40 : int'($urandom_range(0, 3)));
      if (bus.mem_req) begin
         bus.mem_ready = (wl == 0);
         if (wl > 0) wl--;
      end else begin
         bus.mem_ready = rnd_mode && ($urandom_range(0, 7) == 0);
      end
      r_prev_req = bus.mem_req;
      if (rnd_mode) rd_val = $urandom;
      bus.mem_rdata = rd_val;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  hi;
      bit  got;
      reset = 1; i_if_req = 0; i_if_addr = '0; i_flush = 0;
      i_dm_req = 0; i_dm_we = 0; i_dm_addr = '0; i_dm_wdata = '0; i_dm_be = '0;
      bus.mem_ready = 0; bus.mem_rdata = '0;
      repeat (3) step();
      check("rst_mem_req", bus.mem_req, 0);
      check("rst_if_valid", o_if_valid, 0);
      reset = 0;
      step();

      // Zero-wait fetch
      i_if_req = 1; i_if_addr = 32'h100; rd_val = 32'h13; next_wait = 0;
      #1 check("t1_stall_c0", o_stall_if, 1);
      step();
      check("t1_req", bus.mem_req, 1);
      check("t1_addr", bus.mem_addr, 32'h100);
      check("t1_we", bus.mem_we, 0);
      check("t1_stall_c1", o_stall_if, 1);
      step();
      check("t1_valid", o_if_valid, 1);
      check("t1_rdata", o_if_rdata, 32'h13);
      i_if_req = 0;
      step();

      // Store and fetch requested together: store wins
      i_dm_req = 1; i_dm_we = 1; i_dm_addr = 32'h2000; i_dm_wdata = 32'hDEADBEEF; i_dm_be = 4'hF;
      i_if_req = 1; i_if_addr = 32'h500;
      step();
      check("t2_we", bus.mem_we, 1);
      check("t2_addr", bus.mem_addr, 32'h2000);
      check("t2_wdata", bus.mem_wdata, 32'hDEADBEEF);
      step();
      check("t2_dm_valid", o_dm_valid, 1);
      i_dm_req = 0;
      step();
      check("t2_if_req", bus.mem_req, 1);
      check("t2_if_addr", bus.mem_addr, 32'h500);
      step();
      check("t2_if_valid", o_if_valid, 1);
      i_if_req = 0;
      step();

      // Five wait states
      i_if_req = 1; i_if_addr = 32'h40; next_wait = 5; rd_val = 32'hCAFE0001;
      for (int i = 0; i < 6; i++) begin
         step();
         check("t3_req", bus.mem_req, 1);
         check("t3_addr", bus.mem_addr, 32'h40);
      end
      step();
      check("t3_valid", o_if_valid, 1);
      check("t3_rdata", o_if_rdata, 32'hCAFE0001);
      i_if_req = 0;
      step();

      // Flush squashes an in-flight fetch
      i_if_req = 1; i_if_addr = 32'h40; next_wait = 3; rd_val = 32'h11111111;
      step();                          // cycle 1
      step();                          // cycle 2
      i_flush = 1; i_if_req = 0;
      step();                          // cycle 3
      i_flush = 0;
      step();                          // cycle 4
      step();                          // cycle 5
      check("t4_no_valid", o_if_valid, 0);
      i_if_req = 1; i_if_addr = 32'h80; next_wait = 0; rd_val = 32'h22222222;
      step();                          // cycle 6
      check("t4_addr", bus.mem_addr, 32'h80);
      step();                          // cycle 7
      check("t4_valid", o_if_valid, 1);
      check("t4_rdata", o_if_rdata, 32'h22222222);
      i_if_req = 0;
      step();

      // Load that never completes
      i_dm_req = 1; i_dm_we = 0; i_dm_addr = 32'h3000;
      i_if_req = 1; i_if_addr = 32'h600; next_wait = 1000;
      hi = 0; got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         step();
         if (bus.mem_req) hi++;
         if (o_dm_valid) got = 1;
      end
      check("t5_req_cycles", hi, 16);
      check("t5_valid", got, 1);
      check("t5_err", o_dm_err, 1);
      check("t5_rdata", o_dm_rdata, 0);
      i_dm_req = 0; next_wait = 0;
      step();
      check("t5_fetch_req", bus.mem_req, 1);
      check("t5_fetch_addr", bus.mem_addr, 32'h600);
      step();
      check("t5_fetch_valid", o_if_valid, 1);
      i_if_req = 0;
      step();

      // Reset during a data access
      i_dm_req = 1; i_dm_we = 0; i_dm_addr = 32'h3100; next_wait = 1000;
      repeat (3) step();
      reset = 1;
      step();
      check("t6_req", bus.mem_req, 0);
      check("t6_valid", o_dm_valid, 0);
      reset = 0; next_wait = 0;
      step();
      check("t6_regrant", bus.mem_req, 1);
      check("t6_addr", bus.mem_addr, 32'h3100);
      step();
      check("t6_valid2", o_dm_valid, 1);
      i_dm_req = 0;
      step();

      // Random traffic
      rnd_mode = 1; next_wait = -1;
      for (int i = 0; i < 3000; i++) begin
         step();
         reset   = ($urandom_range(0, 299) == 0);
         i_flush = ($urandom_range(0, 19) == 0);
         if (!i_if_req || e_if_valid || i_flush) begin
            i_if_req  = ($urandom_range(0, 2) != 0);
            i_if_addr = $urandom & 32'hFFFF_FFFC;
         end
         if (!i_dm_req || e_dm_valid) begin
            i_dm_req   = ($urandom_range(0, 2) == 0);
            i_dm_we    = $urandom_range(0, 1);
            i_dm_addr  = $urandom & 32'hFFFF_FFFC;
            i_dm_wdata = $urandom;
            i_dm_be    = 4'($urandom_range(1, 15));
         end
      end
      reset = 0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares a single unified instruction/data memory port between the fetch stage and the memory stage of the 5-stage KLP32 pipeline. It arbitrates and sequences one memory transaction at a time, and returns read data with a registered valid pulse. It generates per-stage stall signals and discards fetch responses squashed by a control-flow redirect. It also aborts hung transactions with a timeout error.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte enables are DATA_W/8 bits
- TIMEOUT, 16, number of BUSY cycles with mem_ready low before abort (≥2)

Ports:
- clk  input  1  single clock; everything is posedge clk
- reset  input  1  synchronous, active-high; sampled on posedge clk
- i_if_req  input  1  fetch request; held with i_if_addr stable until o_if_valid
- i_if_addr  input  ADDR_W  fetch address
- i_flush  input  1  redirect pulse from execute; squashes any in-flight fetch
- o_if_valid  output  1  one-cycle fetch completion pulse
- o_if_rdata  output  DATA_W  fetched instruction; valid with o_if_valid
- o_if_err  output  1  fetch timed out; valid with o_if_valid
- o_stall_if  output  1  i_if_req && !o_if_valid
- i_dm_req  input  1  data request; held with its address/data stable until o_dm_valid
- i_dm_we  input  1  1 = store, 0 = load
- i_dm_addr  input  ADDR_W  data address
- i_dm_wdata  input  DATA_W  store data
- i_dm_be  input  DATA_W/8  store byte enables
- o_dm_valid  output  1  one-cycle data completion pulse
- o_dm_rdata  output  DATA_W  load data; 0 for stores
- o_dm_err  output  1  data access timed out
- o_stall_mem  output  1  i_dm_req && !o_dm_valid
- mem_req  output  1  memory request; high throughout BUSY states
- mem_we  output  1  latched write enable
- mem_addr  output  ADDR_W  latched address
- mem_wdata  output  DATA_W  latched store data
- mem_be  output  DATA_W/8  latched byte enables; all ones for loads and fetches
- mem_ready  input  1  completion strobe; qualifies mem_rdata for reads
- mem_rdata  input  DATA_W  read data

## Operation
- FSM states are IDLE, BUSY_I and BUSY_D.
- IDLE arbitration:
  - A requester whose o_x_valid is high this cycle is ignored.
  - Data has strict priority over fetch.
  - Fetch is not granted in a cycle with i_flush=1.
  - On grant, latch the address, write enable, data and byte enables, then go to BUSY_x.
- BUSY_x: mem_req=1 and mem_* outputs come from the latched registers. They stay stable until the transaction ends.
- mem_ready=1 in BUSY_x:
  - Register mem_rdata into o_x_rdata (0 for stores).
  - Pulse o_x_valid next cycle with o_x_err=0.
  - Return to IDLE.
- Squash flag: set by i_flush in any cycle from the fetch grant cycle through the BUSY_I completion cycle inclusive. If set at completion:
  - o_if_valid is suppressed and o_if_rdata is unchanged.
  - The flag clears.
  - The fetch stage re-presents its redirected address.
- i_flush has no effect on BUSY_D or on an already-pulsing o_if_valid.
- Timeout:
  - A wait counter clears on grant and increments each BUSY cycle with mem_ready low.
  - When it reaches TIMEOUT−1 with mem_ready still low, abort: drop mem_req next cycle and return to IDLE.
  - Pulse o_x_valid with o_x_err=1 and o_x_rdata=0. A squashed fetch abort produces no pulse.
- A late mem_ready arriving in IDLE is ignored.

## Timing
- Reset: state IDLE, squash flag 0, counter 0. All outputs are 0, including mem_* and o_*_rdata.
- Reset mid-transaction: mem_req is 0 the next cycle and no valid pulse is produced.
- Zero-wait latency:
  - Cycle 0: request seen in IDLE.
  - Cycle 1: mem_req=1 and mem_ready=1.
  - Cycle 2: o_x_valid=1, state IDLE.
- With N wait cycles, o_x_valid occurs in cycle 2+N.
- Throughput is at most one access per 2 cycles. mem_req is low for at least one cycle between transactions.
- o_stall_* are combinational from requests and the registered valids.

## Test plan
- Fetch 0x100, mem_ready in cycle 1, mem_rdata 0x00000013:
  - Cycle 1: mem_req=1, mem_addr=0x100, mem_we=0.
  - Cycle 2: o_if_valid=1, o_if_rdata=0x13.
  - o_stall_if high in cycles 0–1.
- Fetch and store (0x2000, 0xDEADBEEF, be 0xF) both requested in cycle 0, zero-wait:
  - Store is on the bus in cycle 1 with mem_we=1.
  - o_dm_valid in cycle 2, fetch granted in cycle 2.
  - Fetch on the bus in cycle 3, o_if_valid in cycle 4.
- Fetch 0x40 with 5 wait states: mem_addr is stable at 0x40 for 6 BUSY cycles, then o_if_valid and o_if_rdata equal mem_rdata.
- Fetch 0x40, i_flush in cycle 2, mem_ready in cycle 4:
  - No o_if_valid.
  - Fetch of 0x80 presented in cycle 5 completes normally with o_if_valid in cycle 7.
- Load 0x3000 with mem_ready never asserted, TIMEOUT=16:
  - mem_req is high for 16 cycles then drops.
  - o_dm_valid=1, o_dm_err=1, o_dm_rdata=0.
  - A following fetch is granted.
- reset asserted during BUSY_D:
  - Next cycle mem_req=0, state IDLE, no o_dm_valid.
  - A request held across reset release is re-granted normally.
